// File: rtl/snake_engine.sv
// Snake body engine: owns body slots, length, heading and game state, and
// advances the snake one cell per step with wall (kill or wrap) and self-collision handling.
module snake_engine #(
  parameter int WIDTH    = 32,
  parameter int HEIGHT   = 24,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int POS_W    = 10,
  parameter int LEN_W    = 5,
  parameter int WRAP     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     step,
  input  logic [1:0]               di,
  input  logic                     grow,
  output logic [MAX_LEN*POS_W-1:0] body_pos,
  output logic [LEN_W-1:0]         len,
  output logic                     alive,
  output logic                     dead,
  output logic                     moved,
  output logic [1:0]               cause
);

  localparam int COL_W = $clog2(WIDTH + 1);
  localparam int ROW_W = $clog2(HEIGHT + 1);
  localparam int R0    = HEIGHT / 2;
  localparam logic [POS_W-1:0] SENT = '1;

  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  typedef logic [MAX_LEN-1:0][POS_W-1:0] body_t;
  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       cause_reg, cause_next;
  body_t            body_reg, slot_next;
  logic [LEN_W-1:0] len_reg;
  logic [1:0]       dir_reg;
  logic             moved_reg;
  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] row_reg, row_next;

  logic             opposite, grow_eff, step_go, wall_hit, wall_kill;
  logic             self_hit, collide, move, load;
  logic [1:0]       dir_eff;
  logic [POS_W-1:0] head, head_next;
  logic [MAX_LEN-1:0] hit_vec;

  function automatic body_t init_body();
    body_t b;
    for (int k = 0; k < MAX_LEN; k++) begin
      b[k] = (k < INIT_LEN) ? POS_W'(R0 * WIDTH + INIT_LEN - 1 - k) : SENT;
    end
    return b;
  endfunction

  assign head     = body_reg[0];
  assign opposite = (di[1] == dir_reg[1]) && (di[0] != dir_reg[0]);
  assign dir_eff  = opposite ? dir_reg : di;
  assign grow_eff = grow && (len_reg < LEN_W'(MAX_LEN));
  assign step_go  = (state_reg == RUN) && step && !start;

  // Edge test uses the tracked col/row before any arithmetic touches the index.
  always_comb begin
    wall_hit  = 1'b0;
    head_next = head;
    col_next  = col_reg;
    row_next  = row_reg;
    case (dir_eff)
      DIR_LEFT: begin
        if (col_reg == '0) begin
          wall_hit  = 1'b1;
          head_next = head + POS_W'(WIDTH - 1);
          col_next  = COL_W'(WIDTH - 1);
        end else begin
          head_next = head - POS_W'(1);
          col_next  = col_reg - COL_W'(1);
        end
      end
      DIR_RIGHT: begin
        if (col_reg == COL_W'(WIDTH - 1)) begin
          wall_hit  = 1'b1;
          head_next = head - POS_W'(WIDTH - 1);
          col_next  = '0;
        end else begin
          head_next = head + POS_W'(1);
          col_next  = col_reg + COL_W'(1);
        end
      end
      DIR_UP: begin
        if (row_reg == '0) begin
          wall_hit  = 1'b1;
          head_next = head + POS_W'((HEIGHT - 1) * WIDTH);
          row_next  = ROW_W'(HEIGHT - 1);
        end else begin
          head_next = head - POS_W'(WIDTH);
          row_next  = row_reg - ROW_W'(1);
        end
      end
      default: begin
        if (row_reg == ROW_W'(HEIGHT - 1)) begin
          wall_hit  = 1'b1;
          head_next = head - POS_W'((HEIGHT - 1) * WIDTH);
          row_next  = '0;
        end else begin
          head_next = head + POS_W'(WIDTH);
          row_next  = row_reg + ROW_W'(1);
        end
      end
    endcase
  end

  assign wall_kill = wall_hit && (WRAP == 0);

  // The tail slot only counts as an obstacle when it stays put, i.e. on real growth.
  assign hit_vec[0]   = 1'b0;
  assign slot_next[0] = head_next;
  generate
    for (genvar gi = 1; gi < MAX_LEN; gi++) begin : g_slot
      logic in_body, is_tail, keep;
      assign in_body      = LEN_W'(gi) < len_reg;
      assign is_tail      = LEN_W'(gi) == (len_reg - LEN_W'(1));
      assign hit_vec[gi]  = (body_reg[gi] == head_next) && in_body && (!is_tail || grow_eff);
      assign keep         = in_body || ((LEN_W'(gi) == len_reg) && grow_eff);
      assign slot_next[gi] = keep ? body_reg[gi-1] : SENT;
    end
  endgenerate

  assign self_hit = |hit_vec;
  assign collide  = wall_kill || self_hit;
  assign move     = step_go && !collide;
  assign load     = start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cause_reg <= 2'b00;
    end else begin
      state_reg <= state_next;
      cause_reg <= cause_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    if (start) begin
      state_next = RUN;
      cause_next = 2'b00;
    end else if (step_go && collide) begin
      state_next = DEAD;
      cause_next = wall_kill ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      body_reg  <= init_body();
      len_reg   <= LEN_W'(INIT_LEN);
      dir_reg   <= DIR_RIGHT;
      moved_reg <= 1'b0;
      col_reg   <= COL_W'(INIT_LEN - 1);
      row_reg   <= ROW_W'(R0);
    end else begin
      moved_reg <= move;
      if (load) begin
        body_reg <= init_body();
        len_reg  <= LEN_W'(INIT_LEN);
        dir_reg  <= DIR_RIGHT;
        col_reg  <= COL_W'(INIT_LEN - 1);
        row_reg  <= ROW_W'(R0);
      end else begin
        if (step_go) begin
          dir_reg <= dir_eff;
        end
        if (move) begin
          body_reg <= slot_next;
          col_reg  <= col_next;
          row_reg  <= row_next;
          if (grow_eff) begin
            len_reg <= len_reg + LEN_W'(1);
          end
        end
      end
    end
  end

  assign body_pos = body_reg;
  assign len      = len_reg;
  assign moved    = moved_reg;
  assign cause    = cause_reg;
  assign alive    = (state_reg == RUN);
  assign dead     = (state_reg == DEAD);

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: a vector table for the main moves plus
// hand sequences for wall kill/wrap, length saturation and async reset.
module tb_snake_engine;

  localparam int PW = 10;
  localparam int ML = 16;
  localparam int LW = 5;
  localparam int NV = 21;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          step = 1'b0;
  logic          grow = 1'b0;
  logic [1:0]    di = 2'b01;
  logic [ML*PW-1:0] body_pos, w_body_pos;
  logic [LW-1:0] len, w_len;
  logic          alive, dead, moved, w_alive, w_dead, w_moved;
  logic [1:0]    cause, w_cause;

  int n_chk = 0;
  int n_fail = 0;

  snake_engine #(.WRAP(0)) dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .di(di), .grow(grow),
    .body_pos(body_pos), .len(len), .alive(alive), .dead(dead),
    .moved(moved), .cause(cause)
  );

  snake_engine #(.WRAP(1)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .step(step), .di(di), .grow(grow),
    .body_pos(w_body_pos), .len(w_len), .alive(w_alive), .dead(w_dead),
    .moved(w_moved), .cause(w_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic       sp;
    logic [1:0] d;
    logic       gr;
    int         head;
    int         tail;
    int         ln;
    logic       al;
    logic       dd;
    logic [1:0] cs;
    logic       mv;
  } vec_t;

  vec_t vt [NV];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int slot(input logic [ML*PW-1:0] b, input int k);
    return int'(b[k*PW +: PW]);
  endfunction

  task automatic apply(input logic s, input logic p, input logic [1:0] d, input logic g);
    start = s; step = p; di = d; grow = g;
    @(posedge clk);
    #1;
    start = 1'b0; step = 1'b0; grow = 1'b0;
  endtask

  initial begin
    //        st    sp    di     gr    head tail len al    dd    cs     mv
    vt[0]  = '{1'b1, 1'b0, 2'b01, 1'b0, 386, 384, 3, 1'b1, 1'b0, 2'b00, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 2'b01, 1'b0, 387, 385, 3, 1'b1, 1'b0, 2'b00, 1'b1};
    vt[2]  = '{1'b0, 1'b1, 2'b00, 1'b0, 388, 386, 3, 1'b1, 1'b0, 2'b00, 1'b1};
    vt[3]  = '{1'b0, 1'b1, 2'b10, 1'b0, 356, 387, 3, 1'b1, 1'b0, 2'b00, 1'b1};
    vt[4]  = '{1'b0, 1'b1, 2'b11, 1'b0, 324, 388, 3, 1'b1, 1'b0, 2'b00, 1'b1};
    vt[5]  = '{1'b0, 1'b0, 2'b01, 1'b0, 324, 388, 3, 1'b1, 1'b0, 2'b00, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 2'b01, 1'b0, 386, 384, 3, 1'b1, 1'b0, 2'b00, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 2'b01, 1'b1, 387, 384, 4, 1'b1, 1'b0, 2'b00, 1'b1};
    vt[8]  = '{1'b0, 1'b1, 2'b01, 1'b1, 388, 384, 5, 1'b1, 1'b0, 2'b00, 1'b1};
    vt[9]  = '{1'b0, 1'b1, 2'b11, 1'b0, 420, 385, 5, 1'b1, 1'b0, 2'b00, 1'b1};
    vt[10] = '{1'b0, 1'b1, 2'b00, 1'b0, 419, 386, 5, 1'b1, 1'b0, 2'b00, 1'b1};
    vt[11] = '{1'b0, 1'b1, 2'b10, 1'b0, 419, 386, 5, 1'b0, 1'b1, 2'b10, 1'b0};
    vt[12] = '{1'b0, 1'b1, 2'b01, 1'b0, 419, 386, 5, 1'b0, 1'b1, 2'b10, 1'b0};
    vt[13] = '{1'b1, 1'b0, 2'b01, 1'b0, 386, 384, 3, 1'b1, 1'b0, 2'b00, 1'b0};
    vt[14] = '{1'b0, 1'b1, 2'b01, 1'b1, 387, 384, 4, 1'b1, 1'b0, 2'b00, 1'b1};
    vt[15] = '{1'b0, 1'b1, 2'b11, 1'b0, 419, 385, 4, 1'b1, 1'b0, 2'b00, 1'b1};
    vt[16] = '{1'b0, 1'b1, 2'b00, 1'b0, 418, 386, 4, 1'b1, 1'b0, 2'b00, 1'b1};
    vt[17] = '{1'b0, 1'b1, 2'b10, 1'b0, 386, 387, 4, 1'b1, 1'b0, 2'b00, 1'b1};
    vt[18] = '{1'b0, 1'b1, 2'b01, 1'b1, 386, 387, 4, 1'b0, 1'b1, 2'b10, 1'b0};
    vt[19] = '{1'b1, 1'b1, 2'b01, 1'b0, 386, 384, 3, 1'b1, 1'b0, 2'b00, 1'b0};
    vt[20] = '{1'b1, 1'b1, 2'b01, 1'b0, 386, 384, 3, 1'b1, 1'b0, 2'b00, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_slot0", slot(body_pos, 0), 386);
    chk("rst_slot1", slot(body_pos, 1), 385);
    chk("rst_slot2", slot(body_pos, 2), 384);
    for (int k = 3; k < ML; k++) chk($sformatf("rst_slot%0d", k), slot(body_pos, k), 1023);
    chk("rst_len", int'(len), 3);
    chk("rst_alive", int'(alive), 0);
    chk("rst_dead", int'(dead), 0);
    chk("rst_moved", int'(moved), 0);
    chk("rst_cause", int'(cause), 0);
    $display("reset: head=%0d len=%0d alive=%0d", slot(body_pos, 0), len, alive);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_step_ignored_pre", int'(alive), 0);

    for (int i = 0; i < NV; i++) begin
      apply(vt[i].st, vt[i].sp, vt[i].d, vt[i].gr);
      chk($sformatf("v%0d_head", i), slot(body_pos, 0), vt[i].head);
      chk($sformatf("v%0d_tail", i), slot(body_pos, vt[i].ln - 1), vt[i].tail);
      chk($sformatf("v%0d_len", i), int'(len), vt[i].ln);
      chk($sformatf("v%0d_alive", i), int'(alive), int'(vt[i].al));
      chk($sformatf("v%0d_dead", i), int'(dead), int'(vt[i].dd));
      chk($sformatf("v%0d_cause", i), int'(cause), int'(vt[i].cs));
      chk($sformatf("v%0d_moved", i), int'(moved), int'(vt[i].mv));
      chk($sformatf("v%0d_wrap_head", i), slot(w_body_pos, 0), vt[i].head);
      $display("vec %0d: start=%0d step=%0d di=%0d grow=%0d head=%0d len=%0d alive=%0d dead=%0d cause=%0d moved=%0d",
               i, vt[i].st, vt[i].sp, vt[i].d, vt[i].gr, slot(body_pos, 0), len, alive, dead, cause, moved);
    end
    chk("reload_slot3_sentinel", slot(body_pos, 3), 1023);
    chk("reload_slot15_sentinel", slot(body_pos, 15), 1023);

    // Wall: 29 right steps reach col 31, the 30th hits the wall
    for (int i = 1; i <= 29; i++) begin
      apply(1'b0, 1'b1, 2'b01, 1'b0);
      chk($sformatf("wall_run%0d_head", i), slot(body_pos, 0), 386 + i);
    end
    chk("wall_pre_slot2", slot(body_pos, 2), 413);
    apply(1'b0, 1'b1, 2'b01, 1'b0);
    chk("wall_dead", int'(dead), 1);
    chk("wall_alive", int'(alive), 0);
    chk("wall_cause", int'(cause), 1);
    chk("wall_frozen_head", slot(body_pos, 0), 415);
    chk("wall_frozen_slot1", slot(body_pos, 1), 414);
    chk("wall_moved", int'(moved), 0);
    chk("wrap_head", slot(w_body_pos, 0), 384);
    chk("wrap_slot1", slot(w_body_pos, 1), 415);
    chk("wrap_alive", int'(w_alive), 1);
    chk("wrap_moved", int'(w_moved), 1);
    $display("wall: head=%0d dead=%0d cause=%0d | wrap head=%0d alive=%0d",
             slot(body_pos, 0), dead, cause, slot(w_body_pos, 0), w_alive);

    // Growth to saturation
    apply(1'b1, 1'b0, 2'b01, 1'b0);
    chk("sat_start_cause", int'(cause), 0);
    for (int i = 1; i <= 13; i++) begin
      apply(1'b0, 1'b1, 2'b01, 1'b1);
      chk($sformatf("sat_grow%0d_len", i), int'(len), 3 + i);
    end
    chk("sat_head", slot(body_pos, 0), 399);
    chk("sat_tail", slot(body_pos, 15), 384);
    apply(1'b0, 1'b1, 2'b01, 1'b1);
    chk("sat_len_hold", int'(len), 16);
    chk("sat_head2", slot(body_pos, 0), 400);
    chk("sat_tail2", slot(body_pos, 15), 385);
    chk("sat_mid8", slot(body_pos, 8), 392);
    chk("sat_alive", int'(alive), 1);
    chk("sat_wrap_len", int'(w_len), 16);
    $display("saturate: head=%0d len=%0d tail=%0d", slot(body_pos, 0), len, slot(body_pos, 15));

    // Asynchronous reset in the middle of a step cycle
    start = 1'b0; step = 1'b1; di = 2'b01; grow = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_alive", int'(alive), 0);
    chk("async_dead", int'(dead), 0);
    chk("async_head", slot(body_pos, 0), 386);
    chk("async_len", int'(len), 3);
    chk("async_slot3", slot(body_pos, 3), 1023);
    chk("async_moved", int'(moved), 0);
    $display("async reset: head=%0d len=%0d alive=%0d", slot(body_pos, 0), len, alive);
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(1'b0, 1'b1, 2'b01, 1'b0);
    chk("idle_step_head", slot(body_pos, 0), 386);
    chk("idle_step_moved", int'(moved), 0);
    chk("idle_step_alive", int'(alive), 0);
    $display("idle step: head=%0d alive=%0d moved=%0d", slot(body_pos, 0), alive, moved);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
